fetch_pc_unit: RTL

- Instruction-fetch stage sitting directly upstream of the register-decode stage's accelerated branch logic.
- Owns the architectural PC register, generates the instruction-memory address, and computes PC+4.
- Drives the IF/ID pipeline register (instruction, PC, valid) whose PC output feeds the branch unit's pc_out input.
- Consumes the branch unit's BrTaken/pc_br and implements one architectural branch delay slot, plus a fetch counter for debug.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/if_id_reg.sv | 25 ++
 rtl/fetch_pc_unit.sv | 85 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: opcode encoding, the IF/ID bubble word and the IF/ID register layout.
// No logic; types and constants only.
// Imported by the fetch stage and its pipeline register.
package cpu_pkg;

    // Opcode class encoding shared across the pipeline.
    typedef enum logic [3:0] {
        OP_PC_INIT = 4'd0,
        OP_ADDI    = 4'd1,
        OP_ADDS    = 4'd2,
        OP_BLT     = 4'd3,
        OP_B       = 4'd4,
        OP_CBZ     = 4'd5,
        OP_LDUR    = 4'd6,
        OP_LSL     = 4'd7,
        OP_LSR     = 4'd8,
        OP_MUL     = 4'd9,
        OP_STUR    = 4'd10,
        OP_SUBS    = 4'd11,
        OP_INV     = 4'd12
    } opcode_e;

    // Instruction word held in IF/ID while it carries a bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Sequential fetch stride in bytes.
    localparam logic [63:0] PC_STEP = 64'd4;

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        in_delay_slot;
    } if_id_t;

    // Bubble value: PC zero, NOP word, not valid, not a delay slot.
    function automatic if_id_t if_id_bubble(input logic [31:0] nop);
        if_id_t b;
        b.pc            = 64'd0;
        b.instr         = nop;
        b.valid         = 1'b0;
        b.in_delay_slot = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load enable; resets to the bubble value.
// Latency: one cycle from d to q when enabled.
// Backpressure: enable low holds the current contents unchanged.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  if_id_t d,
    output if_id_t q
);

    // Capture the fetched instruction when enabled; async reset to a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= if_id_bubble(BUBBLE_INSTR);
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, PC+4, next-PC select with one branch delay slot, IF/ID register, fetch counter.
// Latency: one cycle from imem fetch to ID; imem_addr is the PC register directly.
// Backpressure: stall freezes PC, IF/ID and counter; a branch held in ID is honoured once on release.
module fetch_pc_unit #(
    parameter logic [63:0] PC_INIT   = 64'd0,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [63:0]      pc_br,
    output logic [63:0]      imem_addr,
    input  logic [31:0]      imem_instr,
    output logic [63:0]      pc_out,
    output logic [31:0]      instr_id,
    output logic             valid_id,
    output logic             in_delay_slot,
    output logic [CNT_W-1:0] fetch_cnt
);
    import cpu_pkg::*;

    logic [63:0]      pc;
    logic [63:0]      pc_plus4;
    logic [63:0]      pc_next;
    logic             br_eff;
    logic             advance;
    if_id_t           id_d;
    if_id_t           id_q;

    // A branch only counts when ID holds a real instruction and the pipe moves;
    // a stalled branch stays in ID and is re-presented on the next free cycle.
    always_comb begin
        advance  = ~stall;
        br_eff   = br_taken & id_q.valid & advance;
        pc_plus4 = pc + PC_STEP;
        pc_next  = br_eff ? pc_br : pc_plus4;
    end

    // The instruction fetched alongside a taken branch is its delay slot:
    // it always enters ID and is tagged so downstream logic can see it.
    always_comb begin
        id_d               = if_id_bubble(NOP_INSTR);
        id_d.pc            = pc;
        id_d.instr         = imem_instr;
        id_d.valid         = 1'b1;
        id_d.in_delay_slot = br_eff;
    end

    // Architectural PC: target after the delay slot, otherwise sequential.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= PC_INIT;
        end else if (advance) begin
            pc <= pc_next;
        end
    end

    // Debug counter of instructions accepted into IF/ID, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt <= '0;
        end else if (advance) begin
            fetch_cnt <= fetch_cnt + CNT_W'(1);
        end
    end

    if_id_reg #(
        .BUBBLE_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .d     (id_d),
        .q     (id_q)
    );

    assign imem_addr     = pc;
    assign pc_out        = id_q.pc;
    assign instr_id      = id_q.instr;
    assign valid_id      = id_q.valid;
    assign in_delay_slot = id_q.in_delay_slot;

endmodule
